// File: rtl/aes_block_sequencer.sv
// AES block sequencer: walks a job of cipher blocks through the engine by
// fetching BLOCK_WORDS words from the source streamer, starting the cipher,
// then draining BLOCK_WORDS result words to the sink streamer, per block.
module aes_block_sequencer #(
  parameter int WORD_BYTES  = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           start_i,
  input  logic [ADDR_W-1:0]              in_addr_i,
  input  logic [ADDR_W-1:0]              out_addr_i,
  input  logic [31:0]                    byte_len_i,
  output logic                           src_req_o,
  output logic [ADDR_W-1:0]              src_addr_o,
  input  logic                           src_ready_i,
  input  logic                           src_done_i,
  output logic                           sink_req_o,
  output logic [ADDR_W-1:0]              sink_addr_o,
  input  logic                           sink_ready_i,
  input  logic                           sink_done_i,
  output logic                           eng_start_o,
  output logic                           eng_load_o,
  output logic                           eng_go_o,
  input  logic                           eng_done_i,
  output logic                           eng_rd_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] eng_word_idx_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [CNT_W-1:0]               blocks_done_o
);

  localparam int IDX_W       = $clog2(BLOCK_WORDS);
  localparam int BLOCK_BYTES = WORD_BYTES * BLOCK_WORDS;
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, RD_REQ, RD_WAIT, CRYPT, WR_REQ, WR_WAIT, NEXT, FINISH, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  in_base_q, in_base_d;
  logic [ADDR_W-1:0]  out_base_q, out_base_d;
  logic [CNT_W-1:0]   nblk_q, nblk_d;
  logic [CNT_W-1:0]   blk_q, blk_d;
  logic [IDX_W-1:0]   word_q, word_d;
  logic               go_q, go_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  xfer_off;
  logic               misaligned;

  // Number of blocks in a job: ceil(len / block bytes), saturated to the counter range.
  function automatic logic [CNT_W-1:0] calc_nblk(input logic [31:0] len);
    logic [32:0] len_rnd;
    logic [32:0] nblk_full;
    len_rnd   = {1'b0, len} + 33'(BLOCK_BYTES - 1);
    nblk_full = len_rnd / 33'(BLOCK_BYTES);
    if (|(nblk_full >> CNT_W)) calc_nblk = '1;
    else                       calc_nblk = CNT_W'(nblk_full);
  endfunction

  // Both streamers share one offset; the adds wrap modulo 2^ADDR_W.
  assign xfer_off = ADDR_W'(blk_q) * ADDR_W'(BLOCK_BYTES)
                  + ADDR_W'(word_q) * ADDR_W'(WORD_BYTES);
  assign src_addr_o     = in_base_q + xfer_off;
  assign sink_addr_o    = out_base_q + xfer_off;
  assign eng_word_idx_o = word_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;
  assign blocks_done_o  = blk_q;
  assign misaligned     = ((in_addr_i  % ADDR_W'(WORD_BYTES)) != '0) ||
                          ((out_addr_i % ADDR_W'(WORD_BYTES)) != '0);

  // Next-state and output decode; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    nblk_d      = nblk_q;
    blk_d       = blk_q;
    word_d      = word_q;
    go_d        = 1'b0;
    err_d       = err_q;
    src_req_o   = 1'b0;
    sink_req_o  = 1'b0;
    eng_start_o = 1'b0;
    eng_load_o  = 1'b0;
    eng_go_o    = 1'b0;
    eng_rd_o    = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        eng_start_o = 1'b1;
        in_base_d   = in_addr_i;
        out_base_d  = out_addr_i;
        nblk_d      = calc_nblk(byte_len_i);
        word_d      = '0;
        blk_d       = '0;
        if (misaligned) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else if (calc_nblk(byte_len_i) == '0) begin
          state_d = FINISH;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        src_req_o = 1'b1;
        if (src_ready_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (src_done_i) begin
          eng_load_o = 1'b1;
          if (word_q == LAST_WORD) begin
            word_d  = '0;
            go_d    = 1'b1;
            state_d = CRYPT;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      CRYPT: begin
        // go_q is only set on the cycle CRYPT is entered.
        eng_go_o = go_q;
        if (eng_done_i) begin
          word_d  = '0;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        sink_req_o = 1'b1;
        if (sink_ready_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (sink_done_i) begin
          eng_rd_o = 1'b1;
          if (word_q == LAST_WORD) begin
            word_d  = '0;
            state_d = NEXT;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = WR_REQ;
          end
        end
      end
      NEXT: begin
        blk_d  = blk_q + 1'b1;
        word_d = '0;
        if (blk_d == nblk_q) state_d = FINISH;
        else                 state_d = RD_REQ;
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      state_d     = IDLE;
      in_base_d   = '0;
      out_base_d  = '0;
      nblk_d      = '0;
      blk_d       = '0;
      word_d      = '0;
      go_d        = 1'b0;
      err_d       = 1'b0;
      src_req_o   = 1'b0;
      sink_req_o  = 1'b0;
      eng_start_o = 1'b0;
      eng_load_o  = 1'b0;
      eng_go_o    = 1'b0;
      eng_rd_o    = 1'b0;
      done_o      = 1'b0;
    end
  end

  // State and job registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      in_base_q  <= '0;
      out_base_q <= '0;
      nblk_q     <= '0;
      blk_q      <= '0;
      word_q     <= '0;
      go_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      nblk_q     <= nblk_d;
      blk_q      <= blk_d;
      word_q     <= word_d;
      go_q       <= go_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer: a table of jobs with hand-computed
// expectations, plus a hand-written clear-during-write sequence.
module tb_aes_block_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, clear, start_i;
  logic [31:0] in_addr, out_addr, byte_len;
  logic        src_req_o, src_ready_i, src_done_i;
  logic [31:0] src_addr_o, sink_addr_o;
  logic        sink_req_o, sink_ready_i, sink_done_i;
  logic        eng_start_o, eng_load_o, eng_go_o, eng_done_i, eng_rd_o;
  logic [1:0]  eng_word_idx_o;
  logic        busy_o, done_o, err_o;
  logic [15:0] blocks_done_o;

  always #5 clk = ~clk;

  aes_block_sequencer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
    .in_addr_i(in_addr), .out_addr_i(out_addr), .byte_len_i(byte_len),
    .src_req_o(src_req_o), .src_addr_o(src_addr_o),
    .src_ready_i(src_ready_i), .src_done_i(src_done_i),
    .sink_req_o(sink_req_o), .sink_addr_o(sink_addr_o),
    .sink_ready_i(sink_ready_i), .sink_done_i(sink_done_i),
    .eng_start_o(eng_start_o), .eng_load_o(eng_load_o), .eng_go_o(eng_go_o),
    .eng_done_i(eng_done_i), .eng_rd_o(eng_rd_o),
    .eng_word_idx_o(eng_word_idx_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .blocks_done_o(blocks_done_o)
  );

  // Handshake responder: 0 = always ready/done, 1 = random, 2 = manual sink_done
  int   hs_mode = 0;
  logic man_sink_done = 1'b0;

  always @(posedge clk) begin
    #1;
    case (hs_mode)
      1: begin
        src_ready_i  = 1'($urandom_range(0, 1));
        src_done_i   = 1'($urandom_range(0, 1));
        sink_ready_i = 1'($urandom_range(0, 1));
        sink_done_i  = 1'($urandom_range(0, 1));
        eng_done_i   = 1'($urandom_range(0, 1));
      end
      2: begin
        src_ready_i  = 1'b1;
        src_done_i   = 1'b1;
        sink_ready_i = 1'b1;
        sink_done_i  = man_sink_done;
        eng_done_i   = 1'b1;
      end
      default: begin
        src_ready_i  = 1'b1;
        src_done_i   = 1'b1;
        sink_ready_i = 1'b1;
        sink_done_i  = 1'b1;
        eng_done_i   = 1'b1;
      end
    endcase
  end

  // Monitor: accepted addresses, strobe counts, word-index sequencing
  logic [31:0] src_q[$];
  logic [31:0] snk_q[$];
  int n_load = 0, n_go = 0, n_rd = 0, n_done = 0, idx_bad = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (src_req_o && src_ready_i)   src_q.push_back(src_addr_o);
      if (sink_req_o && sink_ready_i) snk_q.push_back(sink_addr_o);
      if (eng_load_o) begin
        if (eng_word_idx_o != 2'(n_load % 4)) idx_bad++;
        n_load++;
      end
      if (eng_rd_o) begin
        if (eng_word_idx_o != 2'(n_rd % 4)) idx_bad++;
        n_rd++;
      end
      if (eng_go_o) n_go++;
      if (done_o)   n_done++;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] len;
    logic [31:0] in_a;
    logic [31:0] out_a;
    bit          stall;
    int          words;
    int          blocks;
    int          dones;
    bit          err;
  } vec_t;

  vec_t vecs[7];

  task automatic run_job(input vec_t v, input string nm);
    int s0, k0, l0, g0, r0, d0, ns, nk;
    bit fin;
    logic [31:0] ea;
    hs_mode = v.stall ? 1 : 0;
    s0 = src_q.size(); k0 = snk_q.size();
    l0 = n_load; g0 = n_go; r0 = n_rd; d0 = n_done;
    @(posedge clk); #1;
    in_addr = v.in_a; out_addr = v.out_a; byte_len = v.len; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy_o) begin
        fin = 1'b1;
        break;
      end
    end
    #1;
    chk({nm, " completes"}, 64'(fin), 64'd1);
    ns = src_q.size() - s0;
    nk = snk_q.size() - k0;
    chk({nm, " src words"},  64'(ns), 64'(v.words));
    chk({nm, " sink words"}, 64'(nk), 64'(v.words));
    chk({nm, " loads"},      64'(n_load - l0), 64'(v.words));
    chk({nm, " gos"},        64'(n_go - g0),   64'(v.blocks));
    chk({nm, " rds"},        64'(n_rd - r0),   64'(v.words));
    chk({nm, " done pulses"}, 64'(n_done - d0), 64'(v.dones));
    chk({nm, " blocks_done"}, 64'(blocks_done_o), 64'(v.blocks));
    chk({nm, " err"},        64'(err_o), 64'(v.err));
    for (int i = 0; i < v.words && i < ns; i++) begin
      ea = v.in_a + 32'(i * 4);
      chk($sformatf("%s src addr %0d", nm, i), 64'(src_q[s0 + i]), 64'(ea));
    end
    for (int i = 0; i < v.words && i < nk; i++) begin
      ea = v.out_a + 32'(i * 4);
      chk($sformatf("%s sink addr %0d", nm, i), 64'(snk_q[k0 + i]), 64'(ea));
    end
    repeat (3) @(negedge clk);
    chk({nm, " err hold"},    64'(err_o), 64'(v.err));
    chk({nm, " blocks hold"}, 64'(blocks_done_o), 64'(v.blocks));
  endtask

  initial begin
    bit seen;
    int r0;
    vecs[0] = '{32'd32, 32'h0000_1000, 32'h0000_2000, 1'b0,  8, 2, 1, 1'b0};
    vecs[1] = '{32'd0,  32'h0000_1000, 32'h0000_2000, 1'b0,  0, 0, 1, 1'b0};
    vecs[2] = '{32'd32, 32'h0000_1002, 32'h0000_2000, 1'b0,  0, 0, 0, 1'b1};
    vecs[3] = '{32'd17, 32'h0000_3000, 32'h0000_4000, 1'b0,  8, 2, 1, 1'b0};
    vecs[4] = '{32'd16, 32'hFFFF_FFF8, 32'h0000_0100, 1'b0,  4, 1, 1, 1'b0};
    vecs[5] = '{32'd32, 32'h0000_2000, 32'h0000_2001, 1'b0,  0, 0, 0, 1'b1};
    vecs[6] = '{32'd48, 32'h0000_0500, 32'h0000_0600, 1'b1, 12, 3, 1, 1'b0};

    reset_n = 1'b0; clear = 1'b0; start_i = 1'b0;
    in_addr = '0; out_addr = '0; byte_len = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset busy",     64'(busy_o), 64'd0);
    chk("reset err",      64'(err_o), 64'd0);
    chk("reset done",     64'(done_o), 64'd0);
    chk("reset blocks",   64'(blocks_done_o), 64'd0);
    chk("reset src_req",  64'(src_req_o), 64'd0);
    chk("reset sink_req", 64'(sink_req_o), 64'd0);
    chk("reset src_addr", 64'(src_addr_o), 64'd0);

    for (int j = 0; j < 7; j++) run_job(vecs[j], $sformatf("job%0d", j));

    // Clear while waiting on the first sink word of block 0
    hs_mode = 2;
    man_sink_done = 1'b0;
    @(posedge clk); #1;
    in_addr = 32'h1000; out_addr = 32'h2000; byte_len = 32'd32; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sink_req_o && sink_ready_i) begin
        seen = 1'b1;
        break;
      end
    end
    chk("clr reach WR_REQ", 64'(seen), 64'd1);
    r0 = n_rd;
    man_sink_done = 1'b1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr busy",     64'(busy_o), 64'd0);
    chk("clr blocks",   64'(blocks_done_o), 64'd0);
    chk("clr sink_req", 64'(sink_req_o), 64'd0);
    chk("clr err",      64'(err_o), 64'd0);
    chk("clr src_addr", 64'(src_addr_o), 64'd0);
    @(negedge clk);
    chk("clr late done ignored", 64'(n_rd - r0), 64'd0);
    chk("clr still idle", 64'(busy_o), 64'd0);
    man_sink_done = 1'b0;
    run_job('{32'd16, 32'h0000_1000, 32'h0000_2000, 1'b0, 4, 1, 1, 1'b0}, "restart");

    chk("word index order", 64'(idx_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/aes_block_sequencer.md
AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

Interface
REQ-001 Parameters SHALL be: WORD_BYTES, default 4, bytes per streamer word; BLOCK_WORDS, default 4, words per cipher block; ADDR_W, default 32, address width; CNT_W, default 16, block-counter width.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort to IDLE
- start_i  in  1  job start pulse
- in_addr_i  in  ADDR_W  source base address
- out_addr_i  in  ADDR_W  sink base address
- byte_len_i  in  32  job length in bytes
- src_req_o  out  1  source transfer request
- src_addr_o  out  ADDR_W  source word address
- src_ready_i  in  1  source accepted request
- src_done_i  in  1  source word delivered
- sink_req_o  out  1  sink transfer request
- sink_addr_o  out  ADDR_W  sink word address
- sink_ready_i  in  1  sink accepted request
- sink_done_i  in  1  sink word written
- eng_start_o  out  1  engine job-init pulse
- eng_load_o  out  1  engine input-word strobe
- eng_go_o  out  1  engine cipher-start pulse
- eng_done_i  in  1  engine block complete
- eng_rd_o  out  1  engine output-word strobe
- eng_word_idx_o  out  $clog2(BLOCK_WORDS)  word index within block
- busy_o  out  1  job active
- done_o  out  1  job-complete pulse
- err_o  out  1  sticky configuration error
- blocks_done_o  out  CNT_W  blocks finished in current job

Function
REQ-003 States SHALL be IDLE, LOAD, RD_REQ, RD_WAIT, CRYPT, WR_REQ, WR_WAIT, NEXT, FINISH, ERROR.
REQ-004 IDLE->LOAD on start_i; start_i SHALL be ignored in every other state.
REQ-005 LOAD (1 cycle) SHALL latch in_addr_i, out_addr_i, byte_len_i; assert eng_start_o; compute nblk = ceil(byte_len/(WORD_BYTES*BLOCK_WORDS)), saturated at 2^CNT_W-1; zero word and block counters.
REQ-006 LOAD->ERROR if either latched address is not a multiple of WORD_BYTES; else LOAD->FINISH if nblk==0; else LOAD->RD_REQ.
REQ-007 RD_REQ SHALL hold src_req_o=1 until src_ready_i is sampled high, then go to RD_WAIT; src_req_o=0 in RD_WAIT.
REQ-008 RD_WAIT on src_done_i SHALL assert eng_load_o for that cycle with the current eng_word_idx_o, increment the word counter, and go to CRYPT if the word was BLOCK_WORDS-1, else RD_REQ.
REQ-009 CRYPT SHALL assert eng_go_o only on its first cycle, wait for eng_done_i, then go to WR_REQ with the word counter at 0.
REQ-010 WR_REQ/WR_WAIT SHALL mirror REQ-007/REQ-008 on the sink side: sink_done_i asserts eng_rd_o and advances the word counter; after word BLOCK_WORDS-1, go to NEXT.
REQ-011 NEXT (1 cycle) SHALL increment blocks_done_o, then go to FINISH if the new count equals nblk, else RD_REQ with the word counter at 0.
REQ-012 FINISH SHALL pulse done_o for exactly 1 cycle, then go to IDLE.
REQ-013 ERROR SHALL set err_o for 1 cycle, then go to IDLE. err_o stays high until the next LOAD or clear; done_o is not asserted.
REQ-014 src_addr_o SHALL be in_addr + blk*WORD_BYTES*BLOCK_WORDS + word*WORD_BYTES, truncated to ADDR_W (wrap modulo 2^ADDR_W); sink_addr_o SHALL be computed the same way from out_addr.
REQ-015 busy_o SHALL be 1 in every state except IDLE.
REQ-016 blocks_done_o SHALL hold its final value in IDLE until the next LOAD.
REQ-017 A partial final block SHALL still transfer BLOCK_WORDS words; padding is the software's responsibility.
REQ-018 Handshake inputs arriving outside their waiting state SHALL be ignored; src_done_i and sink_done_i in the same cycle SHALL each be honoured only in their own state.
REQ-019 eng_done_i asserted on the CRYPT entry cycle SHALL be accepted, giving a 1-cycle CRYPT.

Reset
REQ-020 On reset_n=0 (asynchronous), or on clear=1 (synchronous, highest priority), the block SHALL go to IDLE with all counters 0, all outputs 0, and err_o=0, including mid-job. An in-flight streamer done SHALL then be ignored.

Verification
REQ-021 Defaults, len=32, in=0x1000, out=0x2000, ready/done immediate -> source addresses 0x1000..0x101C, sink addresses 0x2000..0x201C; 8 eng_load_o, 2 eng_go_o, 8 eng_rd_o; blocks_done_o=2; one done_o pulse.
REQ-022 len=0 -> LOAD->FINISH; done_o pulse; no src_req_o; blocks_done_o=0.
REQ-023 in_addr=0x1002 -> ERROR; err_o=1 until the next start; no requests; no done_o.
REQ-024 len=17 -> nblk=2; 8 source words transferred.
REQ-025 in=0xFFFFFFF8, len=16 -> source addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-026 clear asserted in WR_WAIT of block 0, then start with len=16 -> clean restart: busy_o drops the next cycle, blocks_done_o=0, source address begins at the base.
